angledist_feeder: RTL and testbench

ANGLEDIST_FEEDER -- requirements
Module: angledist_feeder

---
 rtl/angledist_pkg.sv | 24 ++
 rtl/angledist_feeder.sv | 140 ++++++++++++++
 tb/tb_angledist_feeder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/angledist_pkg.sv
// Shared types for the angle-distance operand feeder: element word type,
// frame geometry and the feeder FSM state encoding.
package angledist_pkg;

  typedef logic [15:0] T;

  localparam int DIM    = 6;
  localparam int NWORDS = 2 * DIM;
  localparam int IW     = $clog2(NWORDS);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // A frame is well formed only if s_last marks exactly the final word.
  function automatic logic frame_error(input logic [IW-1:0] idx, input logic last);
    logic is_final;
    is_final    = (idx == IW'(NWORDS - 1));
    frame_error = (last && !is_final) || (!last && is_final);
  endfunction

endpackage

// File: rtl/angledist_feeder.sv
// Collects a 12-word frame (measurement + reference vectors) into registered
// operand vectors, holds them steady for the external distance unit for a
// fixed latency, then captures and presents the unit's result.
module angledist_feeder
  import angledist_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  T                     s_data_i,
  input  logic                 s_last_i,
  input  logic                 cfg_we_i,
  input  logic [1:0]           cfg_addr_i,
  input  T                     cfg_data_i,
  output T [1:0][DIM-1:0]      din_o,
  output T                     a_o,
  output T                     b_o,
  output T                     c_o,
  input  T                     res_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output T                     m_data_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  state_e            state_q;
  logic [IW-1:0]     idx_q;
  logic [CW-1:0]     cnt_q;
  T [1:0][DIM-1:0]   din_q;
  T                  a_q, b_q, c_q, m_data_q;
  logic              m_valid_q, err_q;

  logic              row_s;
  logic [2:0]        col_s;
  logic [IW-1:0]     col_full_s;
  logic              accept_s;
  logic              ferr_s;

  // Split the flat word index into vector select and element position.
  always_comb begin
    row_s      = 1'b0;
    col_full_s = idx_q;
    if (idx_q >= IW'(DIM)) begin
      row_s      = 1'b1;
      col_full_s = idx_q - IW'(DIM);
    end else begin
      row_s      = 1'b0;
      col_full_s = idx_q;
    end
    col_s    = col_full_s[2:0];
    accept_s = s_valid_i && (state_q == ST_LOAD);
    ferr_s   = frame_error(idx_q, s_last_i);
  end

  // Main feeder FSM: load frame, wait fixed latency, hold result until taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_LOAD;
      idx_q     <= '0;
      cnt_q     <= '0;
      din_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (accept_s) begin
            din_q[row_s][col_s] <= s_data_i;
            if (ferr_s) begin
              idx_q <= '0;
              err_q <= 1'b1;
            end else if (idx_q == IW'(NWORDS - 1)) begin
              idx_q   <= '0;
              cnt_q   <= '0;
              state_q <= ST_WAIT;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == CW'(LAT)) begin
            m_data_q  <= res_i;
            m_valid_q <= 1'b1;
            state_q   <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_HOLD: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            state_q   <= ST_LOAD;
          end
        end
        default: begin
          state_q   <= ST_LOAD;
          idx_q     <= '0;
          cnt_q     <= '0;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient registers; writes while the distance unit is computing are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q <= 16'h0000;
      b_q <= 16'h0000;
      c_q <= 16'h0000;
    end else if (cfg_we_i && (state_q != ST_WAIT)) begin
      case (cfg_addr_i)
        2'd0:    a_q <= cfg_data_i;
        2'd1:    b_q <= cfg_data_i;
        2'd2:    c_q <= cfg_data_i;
        default: ;
      endcase
    end
  end

  assign s_ready_o = (state_q == ST_LOAD);
  assign busy_o    = (state_q != ST_LOAD);
  assign din_o     = din_q;
  assign a_o       = a_q;
  assign b_o       = b_q;
  assign c_o       = c_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_angledist_feeder.sv
// Directed self-checking bench for angledist_feeder (LAT = 2).
module tb_angledist_feeder;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   s_valid_i;
  logic                   s_ready_o;
  logic [15:0]            s_data_i;
  logic                   s_last_i;
  logic                   cfg_we_i;
  logic [1:0]             cfg_addr_i;
  logic [15:0]            cfg_data_i;
  logic [1:0][5:0][15:0]  din_o;
  logic [15:0]            a_o, b_o, c_o;
  logic [15:0]            res_i;
  logic                   m_valid_o;
  logic                   m_ready_i;
  logic [15:0]            m_data_o;
  logic                   busy_o;
  logic                   err_o;

  int checks = 0;
  int errors = 0;

  angledist_feeder #(.LAT(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .din_o(din_o), .a_o(a_o), .b_o(b_o), .c_o(c_o), .res_i(res_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Stimulus only: 12 words base..base+11, last on the 12th, optional idle gaps.
  task automatic send_frame(input logic [15:0] base, input int gapmax);
    for (int i = 0; i < 12; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = base + 16'(i);
      s_last_i  = (i == 11);
      tick();
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      s_data_i  = 16'hBEEF;
      if (i != 11) begin
        for (int g = 0; g < int'($urandom_range(0, gapmax)); g++) tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; s_valid_i = 1'b0; s_data_i = 16'h0000; s_last_i = 1'b0;
    cfg_we_i = 1'b0; cfg_addr_i = 2'd0; cfg_data_i = 16'h0000;
    res_i = 16'h0000; m_ready_i = 1'b0;
    tick(); tick();
    checks++;
    if (din_o !== '0 || a_o !== 16'h0000 || b_o !== 16'h0000 || c_o !== 16'h0000) begin
      errors++; $display("FAIL reset_regs din=%h a=%h b=%h c=%h want 0", din_o, a_o, b_o, c_o);
    end
    checks++;
    if (m_valid_o !== 1'b0 || m_data_o !== 16'h0000 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_out mv=%b md=%h err=%b busy=%b want 0", m_valid_o, m_data_o, err_o, busy_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (s_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", s_ready_o);
    end
  endtask

  task automatic test_basic_frame();
    res_i = 16'hDEAD;
    send_frame(16'd1, 0);
    checks++;
    if (s_ready_o !== 1'b0 || busy_o !== 1'b1 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_wait_entry rdy=%b busy=%b mv=%b want 0 1 0", s_ready_o, busy_o, m_valid_o);
    end
    tick();
    checks++;
    if (m_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early1 mv=%b want 0", m_valid_o); end
    tick();
    checks++;
    if (m_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early2 mv=%b want 0", m_valid_o); end
    res_i = 16'h1234;
    tick();
    res_i = 16'hDEAD;
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 16'h1234) begin
      errors++; $display("FAIL basic_result mv=%b md=%h want 1 1234", m_valid_o, m_data_o);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (din_o[0][k] !== 16'(k + 1) || din_o[1][k] !== 16'(k + 7)) begin
        errors++; $display("FAIL basic_din%0d got %h/%h want %h/%h", k, din_o[0][k], din_o[1][k], 16'(k + 1), 16'(k + 7));
      end
    end
    tick();
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 16'h1234 || s_ready_o !== 1'b0) begin
      errors++; $display("FAIL basic_hold mv=%b md=%h rdy=%b want 1 1234 0", m_valid_o, m_data_o, s_ready_o);
    end
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    checks++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || s_ready_o !== 1'b1) begin
      errors++; $display("FAIL basic_release mv=%b busy=%b rdy=%b want 0 0 1", m_valid_o, busy_o, s_ready_o);
    end
  endtask

  task automatic test_gaps_stall();
    res_i = 16'h1234;
    send_frame(16'd1, 3);
    for (int n = 0; n < 20 && !m_valid_o; n++) tick();
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 16'h1234) begin
      errors++; $display("FAIL gaps_result mv=%b md=%h want 1 1234", m_valid_o, m_data_o);
    end
    checks++;
    if (din_o[0][0] !== 16'd1 || din_o[0][5] !== 16'd6 || din_o[1][0] !== 16'd7 || din_o[1][5] !== 16'd12) begin
      errors++; $display("FAIL gaps_din got %h want frame 1..12", din_o);
    end
    res_i = 16'h5555;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== 16'h1234 || busy_o !== 1'b1) begin
        errors++; $display("FAIL gaps_stall%0d mv=%b md=%h busy=%b want 1 1234 1", n, m_valid_o, m_data_o, busy_o);
      end
    end
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    checks++;
    if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin
      errors++; $display("FAIL gaps_release mv=%b rdy=%b want 0 1", m_valid_o, s_ready_o);
    end
  endtask

  task automatic test_framing_error();
    for (int i = 0; i < 5; i++) begin
      s_valid_i = 1'b1; s_data_i = 16'h0F00 + 16'(i); s_last_i = (i == 4);
      tick();
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || s_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL ferr_early err=%b rdy=%b busy=%b want 1 1 0", err_o, s_ready_o, busy_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL ferr_pulse err=%b want 0", err_o); end
    // Twelfth word without last is also a framing error.
    for (int i = 0; i < 12; i++) begin
      s_valid_i = 1'b1; s_data_i = 16'h0E00 + 16'(i); s_last_i = 1'b0;
      tick();
    end
    s_valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || s_ready_o !== 1'b1) begin
      errors++; $display("FAIL ferr_late err=%b rdy=%b want 1 1", err_o, s_ready_o);
    end
    res_i = 16'h0777;
    send_frame(16'd101, 0);
    for (int n = 0; n < 20 && !m_valid_o; n++) tick();
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 16'h0777 || din_o[0][0] !== 16'd101 || din_o[1][5] !== 16'd112) begin
      errors++; $display("FAIL ferr_recover mv=%b md=%h d00=%h d15=%h want 1 0777 0065 0070", m_valid_o, m_data_o, din_o[0][0], din_o[1][5]);
    end
    m_ready_i = 1'b1; tick(); m_ready_i = 1'b0;
  endtask

  task automatic test_cfg();
    cfg_we_i = 1'b1; cfg_addr_i = 2'd0; cfg_data_i = 16'hFF4D;
    tick();
    cfg_we_i = 1'b0;
    checks++;
    if (a_o !== 16'hFF4D) begin errors++; $display("FAIL cfg_a got %h want ff4d", a_o); end
    send_frame(16'd200, 0);
    cfg_we_i = 1'b1; cfg_addr_i = 2'd1; cfg_data_i = 16'h0002;
    tick();
    cfg_we_i = 1'b0;
    checks++;
    if (b_o !== 16'h0000 || a_o !== 16'hFF4D) begin
      errors++; $display("FAIL cfg_wait_drop b=%h a=%h want 0000 ff4d", b_o, a_o);
    end
    for (int n = 0; n < 20 && !m_valid_o; n++) tick();
    cfg_we_i = 1'b1; cfg_addr_i = 2'd2; cfg_data_i = 16'h5A5A;
    tick();
    cfg_addr_i = 2'd3; cfg_data_i = 16'hABCD;
    tick();
    cfg_we_i = 1'b0;
    checks++;
    if (c_o !== 16'h5A5A || a_o !== 16'hFF4D || b_o !== 16'h0000) begin
      errors++; $display("FAIL cfg_hold a=%h b=%h c=%h want ff4d 0000 5a5a", a_o, b_o, c_o);
    end
    m_ready_i = 1'b1; tick(); m_ready_i = 1'b0;
  endtask

  task automatic test_reset_midway();
    for (int i = 0; i < 7; i++) begin
      s_valid_i = 1'b1; s_data_i = 16'h0300 + 16'(i); s_last_i = 1'b0;
      tick();
    end
    s_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    checks++;
    if (din_o !== '0 || a_o !== 16'h0000 || c_o !== 16'h0000 || m_data_o !== 16'h0000 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_frame din=%h a=%h c=%h md=%h mv=%b want 0", din_o, a_o, c_o, m_data_o, m_valid_o);
    end
    tick();
    rst_i = 1'b0;
    #1;
    res_i = 16'h0A0A;
    send_frame(16'd31, 0);
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rst_frame_after err=%b busy=%b want 0 1", err_o, busy_o);
    end
    // Reset while waiting on the distance unit.
    rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || m_valid_o !== 1'b0 || din_o !== '0) begin
      errors++; $display("FAIL rst_wait busy=%b mv=%b din=%h want 0", busy_o, m_valid_o, din_o);
    end
    tick();
    rst_i = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin
        errors++; $display("FAIL rst_wait_quiet%0d mv=%b rdy=%b want 0 1", n, m_valid_o, s_ready_o);
      end
    end
    res_i = 16'h0B0B;
    send_frame(16'd41, 0);
    for (int n = 0; n < 20 && !m_valid_o; n++) tick();
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 16'h0B0B || din_o[0][0] !== 16'd41 || din_o[1][5] !== 16'd52) begin
      errors++; $display("FAIL rst_clean mv=%b md=%h d00=%h d15=%h want 1 0b0b 0029 0034", m_valid_o, m_data_o, din_o[0][0], din_o[1][5]);
    end
    m_ready_i = 1'b1; tick(); m_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    m_ready_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      res_i = 16'hA000 + 16'(f);
      send_frame(16'(16'h0100 * (f + 1)), 0);
      checks++;
      if (s_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_final%0d rdy=%b want 0", f, s_ready_o); end
      for (int n = 0; n < 20 && !m_valid_o; n++) begin
        tick();
        if (s_ready_o !== 1'b0) begin
          checks++; errors++; $display("FAIL b2b_ready_wait%0d rdy=%b want 0", f, s_ready_o);
        end
      end
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== 16'hA000 + 16'(f) || din_o[0][0] !== 16'(16'h0100 * (f + 1))) begin
        errors++; $display("FAIL b2b_result%0d mv=%b md=%h d00=%h want 1 %h %h", f, m_valid_o, m_data_o, din_o[0][0], 16'hA000 + 16'(f), 16'(16'h0100 * (f + 1)));
      end
      tick();
      checks++;
      if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin
        errors++; $display("FAIL b2b_release%0d mv=%b rdy=%b want 0 1", f, m_valid_o, s_ready_o);
      end
    end
    m_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gaps_stall();
    test_framing_error();
    test_cfg();
    test_reset_midway();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
